pq_symbol_unpacker: RTL and testbench

Serializes a parallel word of `PQ_SYMBOLS` packed 4-bit symbols into a stream of one symbol per cycle. It is the receive-side counterpart of the symbol packer that produces `o_all_symbols_4b`. It sits between the packed-symbol bus and per-symbol consumers, with valid/ready handshakes on both sides. It supports partial words and back-to-back words with zero bubble cycles.

---
 rtl/pq_symbol_unpacker.sv | 107 ++++++++++
 tb/tb_pq_symbol_unpacker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_symbol_unpacker.sv
// Unpacks a word of PQ_SYMBOLS packed 4-bit symbols into one symbol per cycle.
// Optional macro PQ_UNPACK_MSB_FIRST_EN selects MSB-first emission order.
module pq_symbol_unpacker #(
    parameter int  PQ_SYMBOLS = 8,
    localparam int CNT_W      = $clog2(PQ_SYMBOLS + 1),
    localparam int IDX_W      = $clog2(PQ_SYMBOLS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [PQ_SYMBOLS*4-1:0] i_all_symbols_4b,
    input  logic [CNT_W-1:0]        i_num_symbols,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [3:0]              o_symbol_4b,
    output logic [IDX_W-1:0]        o_index,
    output logic                    o_last
);

    localparam int W = PQ_SYMBOLS * 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             live_q, live_d;

    logic             sending;
    logic             is_last;
    logic             xfer;
    logic             accept;
    logic [CNT_W-1:0] n_eff;
    logic [3:0]       cur_sym;
    logic [W-1:0]     shifted;

`ifdef PQ_UNPACK_MSB_FIRST_EN
    assign cur_sym = shift_q[W-1 -: 4];
    assign shifted = {shift_q[W-5:0], 4'h0};
`else
    assign cur_sym = shift_q[3:0];
    assign shifted = {4'h0, shift_q[W-1:4]};
`endif

    // Handshakes: a word moves when i_valid & o_ready, a symbol when o_valid & i_ready.
    // live_q keeps o_ready low until the first clock after reset release.
    assign sending = (state_q == SEND);
    assign is_last = sending && (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
    assign xfer    = sending && i_ready;
    assign o_ready = live_q && i_en && (!sending || (xfer && is_last));
    assign accept  = i_valid && o_ready;
    assign n_eff   = (i_num_symbols > CNT_W'(PQ_SYMBOLS)) ? CNT_W'(PQ_SYMBOLS) : i_num_symbols;

    assign o_valid     = sending;
    assign o_symbol_4b = sending ? cur_sym : 4'h0;
    assign o_index     = sending ? idx_q : '0;
    assign o_last      = is_last;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        idx_d   = idx_q;
        live_d  = 1'b1;
        // Accepting while sending only happens on the last transfer, so a load covers both.
        if (accept) begin
            if (n_eff != '0) begin
                state_d = SEND;
                shift_d = i_all_symbols_4b;
                count_d = n_eff;
                idx_d   = '0;
            end else begin
                state_d = IDLE;
            end
        end else if (xfer) begin
            if (is_last) begin
                state_d = IDLE;
            end else begin
                shift_d = shifted;
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: tb/tb_pq_symbol_unpacker.sv
// Self-checking bench for pq_symbol_unpacker (PQ_SYMBOLS=8): directed scenarios plus
// randomized traffic checked by a symbol-queue reference model.
module tb_pq_symbol_unpacker;

    localparam int P     = 8;
    localparam int W     = P * 4;
    localparam int CNT_W = $clog2(P + 1);
    localparam int IDX_W = $clog2(P);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_en;
    logic             i_valid;
    logic             o_ready;
    logic [W-1:0]     i_all_symbols_4b;
    logic [CNT_W-1:0] i_num_symbols;
    logic             o_valid;
    logic             i_ready;
    logic [3:0]       o_symbol_4b;
    logic [IDX_W-1:0] o_index;
    logic             o_last;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected symbols in emission order: {last, index, symbol}.
    logic [7:0] exp_q[$];
    logic       m_live;

    pq_symbol_unpacker #(.PQ_SYMBOLS(P)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_en             (i_en),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_all_symbols_4b (i_all_symbols_4b),
        .i_num_symbols    (i_num_symbols),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_symbol_4b      (o_symbol_4b),
        .o_index          (o_index),
        .o_last           (o_last)
    );

    always #5 clk = ~clk;

    // Symbol emitted k-th (k from 0) for a given packed word.
    function automatic logic [3:0] exp_sym(input logic [W-1:0] word, input int k);
`ifdef PQ_UNPACK_MSB_FIRST_EN
        return word[4*(P-1-k) +: 4];
`else
        return word[4*k +: 4];
`endif
    endfunction

    function automatic int clamp_n(input int n);
        return (n > P) ? P : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] w, input int n, input logic rdy);
        i_valid          = v;
        i_all_symbols_4b = w;
        i_num_symbols    = CNT_W'(n);
        i_ready          = rdy;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_live <= 1'b0;
        else        m_live <= 1'b1;
    end

    // Scoreboard: compares every cycle against the queue model, then advances it.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        int   n;
        if (!rst_n) begin
            exp_q.delete();
            n_checks++; if (o_valid !== 1'b0) $display("FAIL sb_rst_valid: got %0b expected 0", o_valid); else n_pass++;
            n_checks++; if (o_ready !== 1'b0) $display("FAIL sb_rst_ready: got %0b expected 0", o_ready); else n_pass++;
        end else begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = m_live && i_en && (exp_q.size() == 0 || (exp_q.size() == 1 && i_ready));
            n_checks++; if (o_valid !== exp_valid) $display("FAIL sb_valid: got %0b expected %0b", o_valid, exp_valid); else n_pass++;
            n_checks++; if (o_ready !== exp_ready) $display("FAIL sb_ready: got %0b expected %0b", o_ready, exp_ready); else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if ({o_last, o_index, o_symbol_4b} !== exp_q[0])
                    $display("FAIL sb_symbol: got last=%0b idx=%0d sym=%0h expected last=%0b idx=%0d sym=%0h",
                             o_last, o_index, o_symbol_4b, exp_q[0][7], exp_q[0][6:4], exp_q[0][3:0]);
                else n_pass++;
                if (i_ready) void'(exp_q.pop_front());
            end
            if (i_valid && exp_ready) begin
                n = clamp_n(int'(i_num_symbols));
                for (int k = 0; k < n; k++)
                    exp_q.push_back({(k == n - 1), 3'(k), exp_sym(i_all_symbols_4b, k)});
            end
        end
    end

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++; if ({o_valid, o_symbol_4b, o_index, o_last} !== '0) $display("FAIL reset_outputs: got %0h expected 0", {o_valid, o_symbol_4b, o_index, o_last}); else n_pass++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_word();
        logic [W-1:0] w = 32'h7654_3210;
        tick(); drive(1'b1, w, 8, 1'b1);
        @(negedge clk);
        n_checks++; if (o_ready !== 1'b1) $display("FAIL full_accept: got %0b expected 1", o_ready); else n_pass++;
        for (int c = 1; c <= 9; c++) begin
            tick(); drive(1'b0, '0, 0, 1'b1);
            @(negedge clk);
            if (c <= 8) begin
                n_checks++; if (o_symbol_4b !== exp_sym(w, c - 1)) $display("FAIL full_sym: cycle %0d got %0h expected %0h", c, o_symbol_4b, exp_sym(w, c - 1)); else n_pass++;
                n_checks++; if (o_last !== (c == 8)) $display("FAIL full_last: cycle %0d got %0b expected %0b", c, o_last, (c == 8)); else n_pass++;
            end else begin
                n_checks++; if (o_valid !== 1'b0) $display("FAIL full_end: got %0b expected 0", o_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w = 32'h7654_3210;
        int k;
        tick(); drive(1'b1, w, 8, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            tick(); drive(1'b0, '0, 0, !(c >= 2 && c <= 4));
            @(negedge clk);
            k = (c <= 1) ? c - 1 : (c <= 5 ? 1 : c - 4);
            if (c <= 11) begin
                n_checks++; if (o_symbol_4b !== exp_sym(w, k)) $display("FAIL bp_sym: cycle %0d got %0h expected %0h", c, o_symbol_4b, exp_sym(w, k)); else n_pass++;
                n_checks++; if (o_last !== (c == 11)) $display("FAIL bp_last: cycle %0d got %0b expected %0b", c, o_last, (c == 11)); else n_pass++;
            end else begin
                n_checks++; if (o_valid !== 1'b0) $display("FAIL bp_end: got %0b expected 0", o_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] ww = 64'hFEDC_BA98_7654_3210;
        tick(); drive(1'b1, ww[W-1:0], 8, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            tick(); drive(c <= 8, ww[2*W-1:W], 8, 1'b1);
            @(negedge clk);
            if (c <= 16) begin
                n_checks++;
                if (!o_valid || o_symbol_4b !== exp_sym(c <= 8 ? ww[W-1:0] : ww[2*W-1:W], (c - 1) % 8))
                    $display("FAIL b2b_sym: cycle %0d got v=%0b sym=%0h expected sym=%0h", c, o_valid, o_symbol_4b,
                             exp_sym(c <= 8 ? ww[W-1:0] : ww[2*W-1:W], (c - 1) % 8));
                else n_pass++;
            end else begin
                n_checks++; if (o_valid !== 1'b0) $display("FAIL b2b_end: got %0b expected 0", o_valid); else n_pass++;
            end
            if (c <= 8) begin
                n_checks++; if (o_ready !== (c == 8)) $display("FAIL b2b_ready: cycle %0d got %0b expected %0b", c, o_ready, (c == 8)); else n_pass++;
            end
        end
    endtask

    task automatic test_partial_and_empty();
        logic [W-1:0] w = 32'h0000_0CBA;
        logic [W-1:0] w2 = 32'h7654_3210;
        tick(); drive(1'b1, w, 3, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick(); drive(1'b0, '0, 0, 1'b1);
            @(negedge clk);
            n_checks++; if (o_symbol_4b !== exp_sym(w, c - 1) || o_last !== (c == 3)) $display("FAIL part_sym: cycle %0d got %0h/%0b expected %0h/%0b", c, o_symbol_4b, o_last, exp_sym(w, c - 1), (c == 3)); else n_pass++;
        end
        tick(); drive(1'b1, w2, 0, 1'b1);
        @(negedge clk);
        n_checks++; if (o_ready !== 1'b1) $display("FAIL empty_ready: got %0b expected 1", o_ready); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            tick(); drive(1'b0, '0, 0, 1'b1);
            @(negedge clk);
            n_checks++; if (o_valid !== 1'b0) $display("FAIL empty_valid: cycle %0d got %0b expected 0", c, o_valid); else n_pass++;
        end
        tick(); drive(1'b1, w2, 12, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            tick(); drive(1'b0, '0, 0, 1'b1);
            @(negedge clk);
            n_checks++; if (o_valid !== (c <= 8) || o_last !== (c == 8)) $display("FAIL clamp: cycle %0d got v=%0b last=%0b expected v=%0b last=%0b", c, o_valid, o_last, (c <= 8), (c == 8)); else n_pass++;
        end
    endtask

    task automatic test_enable_and_reset();
        logic [W-1:0] w = 32'h7654_3210;
        logic [W-1:0] w2 = 32'h0000_00BA;
        tick(); i_en = 1'b0; drive(1'b1, w, 4, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (o_ready !== 1'b0 || o_valid !== 1'b0) $display("FAIL enable_block: got rdy=%0b v=%0b expected 0/0", o_ready, o_valid); else n_pass++;
            tick();
        end
        i_en = 1'b1; drive(1'b1, w, 8, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick(); drive(1'b0, '0, 0, 1'b1);
        end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if ({o_valid, o_symbol_4b, o_index, o_last, o_ready} !== '0) $display("FAIL midreset_outputs: got %0h expected 0", {o_valid, o_symbol_4b, o_index, o_last, o_ready}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); drive(1'b1, w2, 2, 1'b1);
        @(negedge clk);
        n_checks++; if (o_ready !== 1'b1) $display("FAIL postreset_ready: got %0b expected 1", o_ready); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            tick(); drive(1'b0, '0, 0, 1'b1);
            @(negedge clk);
            if (c <= 2) begin
                n_checks++; if (o_symbol_4b !== exp_sym(w2, c - 1) || o_last !== (c == 2)) $display("FAIL postreset_sym: cycle %0d got %0h/%0b expected %0h/%0b", c, o_symbol_4b, o_last, exp_sym(w2, c - 1), (c == 2)); else n_pass++;
            end else begin
                n_checks++; if (o_valid !== 1'b0) $display("FAIL postreset_end: got %0b expected 0", o_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            tick();
            i_en = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 12), $urandom_range(0, 9) < 7);
        end
        drive(1'b0, '0, 0, 1'b1);
        i_en = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        n_checks++; if (exp_q.size() != 0) $display("FAIL random_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        i_en = 1'b1;
        drive(1'b0, '0, 0, 1'b1);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_back_to_back();
        test_partial_and_empty();
        test_enable_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
